// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM state
// encoding and parameter defaults used by the controller and its interface.
package hazard_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } state_e;

  localparam int DRAIN_CYCLES_DEF = 4;
  localparam int CNT_W_DEF        = 16;

endpackage

// File: rtl/hazard_if.sv
// Bundle of pipeline-side signals exchanged with the hazard controller.
// The pipeline (master) supplies ID/EX register fields and halt requests;
// the controller (slave) returns stage steering and performance counts.
interface hazard_if import hazard_pkg::*; #(
  parameter int CNT_W = CNT_W_DEF
);

  logic [4:0]       Rs_ID;
  logic [4:0]       Rt_ID;
  logic             UseRs_ID;
  logic             UseRt_ID;
  logic [4:0]       Rw_Ex;
  logic             RegWr_Ex;
  logic             MemToReg_Ex;
  logic             BranchTaken_Ex;
  logic             halt_req;
  logic             resume;

  logic             pc_hold;
  logic             ifid_hold;
  logic             ifid_flush;
  logic             idex_bubble;
  logic             PC_Src;
  logic             halted;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output Rs_ID, Rt_ID, UseRs_ID, UseRt_ID, Rw_Ex, RegWr_Ex, MemToReg_Ex,
           BranchTaken_Ex, halt_req, resume,
    input  pc_hold, ifid_hold, ifid_flush, idex_bubble, PC_Src, halted,
           stall_cnt, flush_cnt
  );

  modport slave (
    input  Rs_ID, Rt_ID, UseRs_ID, UseRt_ID, Rw_Ex, RegWr_Ex, MemToReg_Ex,
           BranchTaken_Ex, halt_req, resume,
    output pc_hold, ifid_hold, ifid_flush, idex_bubble, PC_Src, halted,
           stall_cnt, flush_cnt
  );

endinterface

// File: rtl/hazard_ctrl_sat_counter.sv
// Saturating up-counter used for the hazard performance statistics.
// Sticks at all-ones so a long run never reports a misleadingly small count.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc_i,
  output logic [W-1:0] count_o
);

  logic [W-1:0] count_q;

  // Count up on request unless already at the ceiling; reset clears.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else if (inc_i && (count_q != {W{1'b1}})) begin
      count_q <= count_q + W'(1);
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: detects load-use hazards, steers flushes on
// taken branches, and sequences a halt by draining the back end of the
// pipeline before freezing it until a resume pulse arrives.
module hazard_ctrl import hazard_pkg::*; #(
  parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEF,
  parameter int CNT_W        = CNT_W_DEF
) (
  input logic     clk,
  input logic     rst,
  hazard_if.slave hz
);

  localparam int DCW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  state_e         state_q, state_d;
  logic [DCW-1:0] drainCnt_q, drainCnt_d;

  logic loadUse;
  logic stallInc, flushInc;
  logic pcHold, ifidHold, ifidFlush, idexBubble, pcSrc, haltedOut;

  // A load in EX whose destination a live ID source needs; $0 never conflicts.
  assign loadUse = hz.MemToReg_Ex && hz.RegWr_Ex && (hz.Rw_Ex != 5'd0) &&
                   ((hz.UseRs_ID && (hz.Rs_ID == hz.Rw_Ex)) ||
                    (hz.UseRt_ID && (hz.Rt_ID == hz.Rw_Ex)));

  // Next-state and output decode; reset forces every control output low so
  // nothing from an interrupted stall or drain leaks into the pipeline.
  always_comb begin
    state_d    = state_q;
    drainCnt_d = drainCnt_q;
    pcHold     = 1'b0;
    ifidHold   = 1'b0;
    ifidFlush  = 1'b0;
    idexBubble = 1'b0;
    pcSrc      = 1'b0;
    haltedOut  = 1'b0;
    stallInc   = 1'b0;
    flushInc   = 1'b0;
    if (!rst) begin
      case (state_q)
        RUN: begin
          if (hz.BranchTaken_Ex) begin
            pcSrc      = 1'b1;
            ifidFlush  = 1'b1;
            idexBubble = 1'b1;
            flushInc   = 1'b1;
          end else if (loadUse) begin
            pcHold     = 1'b1;
            ifidHold   = 1'b1;
            idexBubble = 1'b1;
            stallInc   = 1'b1;
          end
          if (hz.halt_req) begin
            state_d    = DRAIN;
            drainCnt_d = DCW'(DRAIN_CYCLES - 1);
          end
        end
        DRAIN: begin
          pcHold    = 1'b1;
          ifidFlush = 1'b1;
          if (hz.BranchTaken_Ex) begin
            pcSrc      = 1'b1;
            pcHold     = 1'b0;
            idexBubble = 1'b1;
            flushInc   = 1'b1;
          end else if (loadUse) begin
            idexBubble = 1'b1;
          end
          if (drainCnt_q == '0) begin
            state_d = HALTED;
          end else begin
            drainCnt_d = drainCnt_q - DCW'(1);
          end
        end
        HALTED: begin
          haltedOut  = 1'b1;
          pcHold     = 1'b1;
          ifidFlush  = 1'b1;
          idexBubble = 1'b1;
          if (hz.resume) begin
            state_d = RUN;
          end
        end
        default: state_d = RUN;
      endcase
    end
  end

  // State and drain-counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= RUN;
      drainCnt_q <= '0;
    end else begin
      state_q    <= state_d;
      drainCnt_q <= drainCnt_d;
    end
  end

  assign hz.pc_hold     = pcHold;
  assign hz.ifid_hold   = ifidHold;
  assign hz.ifid_flush  = ifidFlush;
  assign hz.idex_bubble = idexBubble;
  assign hz.PC_Src      = pcSrc;
  assign hz.halted      = haltedOut;

  sat_counter #(.W(CNT_W)) uStallCnt (
    .clk     (clk),
    .rst     (rst),
    .inc_i   (stallInc),
    .count_o (hz.stall_cnt)
  );

  sat_counter #(.W(CNT_W)) uFlushCnt (
    .clk     (clk),
    .rst     (rst),
    .inc_i   (flushInc),
    .count_o (hz.flush_cnt)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: a vector table for RUN-state decode plus
// hand-written sequences for halt/drain/resume, reset abort and saturation.
module tb_hazard_ctrl;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  hazard_if #(.CNT_W(16)) hzIf ();

  hazard_ctrl #(.DRAIN_CYCLES(4), .CNT_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .hz  (hzIf.slave)
  );

  // Expected output bit order: {pc_hold, ifid_hold, ifid_flush, idex_bubble, PC_Src, halted}
  typedef struct {
    logic [4:0] rs;
    logic [4:0] rt;
    logic       useRs;
    logic       useRt;
    logic [4:0] rw;
    logic       regWr;
    logic       memToReg;
    logic       branch;
    logic [5:0] expOut;
  } vec_t;

  localparam logic [5:0] O_NONE   = 6'b000000;
  localparam logic [5:0] O_STALL  = 6'b110100;
  localparam logic [5:0] O_BRANCH = 6'b001110;
  localparam logic [5:0] O_DRAIN  = 6'b101000;
  localparam logic [5:0] O_DRLU   = 6'b101100;
  localparam logic [5:0] O_HALTED = 6'b101101;

  vec_t vecs[10];
  vec_t idleV, luV, brV;
  int checks = 0;
  int errors = 0;
  int stallExp = 0;
  int flushExp = 0;

  function automatic vec_t mkVec(input logic [4:0] rs, input logic [4:0] rt,
                                 input logic useRs, input logic useRt,
                                 input logic [4:0] rw, input logic regWr,
                                 input logic memToReg, input logic branch,
                                 input logic [5:0] expOut);
    vec_t v;
    v.rs = rs; v.rt = rt; v.useRs = useRs; v.useRt = useRt; v.rw = rw;
    v.regWr = regWr; v.memToReg = memToReg; v.branch = branch; v.expOut = expOut;
    return v;
  endfunction

  function automatic logic [5:0] outBits();
    return {hzIf.pc_hold, hzIf.ifid_hold, hzIf.ifid_flush, hzIf.idex_bubble,
            hzIf.PC_Src, hzIf.halted};
  endfunction

  function automatic int bump(input int c);
    return (c >= 65535) ? 65535 : c + 1;
  endfunction

  task automatic applyStimulus(input vec_t v, input logic haltReq, input logic resumeIn);
    hzIf.Rs_ID          = v.rs;
    hzIf.Rt_ID          = v.rt;
    hzIf.UseRs_ID       = v.useRs;
    hzIf.UseRt_ID       = v.useRt;
    hzIf.Rw_Ex          = v.rw;
    hzIf.RegWr_Ex       = v.regWr;
    hzIf.MemToReg_Ex    = v.memToReg;
    hzIf.BranchTaken_Ex = v.branch;
    hzIf.halt_req       = haltReq;
    hzIf.resume         = resumeIn;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic checkCounters(input string tag);
    checkOutput({tag, "_stall_cnt"}, 32'(hzIf.stall_cnt), 32'(stallExp));
    checkOutput({tag, "_flush_cnt"}, 32'(hzIf.flush_cnt), 32'(flushExp));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One clocked step: drive, check combinational outputs, clock, update model
  task automatic step(input string name, input vec_t v, input logic haltReq,
                      input logic resumeIn, input logic [5:0] expOut,
                      input bit countStall, input bit countFlush);
    applyStimulus(v, haltReq, resumeIn);
    #1;
    checkOutput(name, 32'(outBits()), 32'(expOut));
    tick();
    if (countStall) stallExp = bump(stallExp);
    if (countFlush) flushExp = bump(flushExp);
  endtask

  initial begin
    idleV = mkVec(0, 0, 0, 0, 0, 0, 0, 0, O_NONE);
    luV   = mkVec(8, 0, 1, 0, 8, 1, 1, 0, O_STALL);
    brV   = mkVec(0, 0, 0, 0, 0, 0, 0, 1, O_BRANCH);

    vecs[0] = idleV;
    vecs[1] = luV;
    vecs[2] = mkVec(0, 0, 1, 0, 0, 1, 1, 0, O_NONE);
    vecs[3] = mkVec(0, 5, 0, 1, 5, 1, 1, 0, O_STALL);
    vecs[4] = mkVec(8, 0, 0, 0, 8, 1, 1, 0, O_NONE);
    vecs[5] = mkVec(8, 0, 1, 0, 8, 1, 0, 0, O_NONE);
    vecs[6] = mkVec(8, 0, 1, 0, 8, 0, 1, 0, O_NONE);
    vecs[7] = brV;
    vecs[8] = mkVec(8, 0, 1, 0, 8, 1, 1, 1, O_BRANCH);
    vecs[9] = mkVec(9, 9, 1, 1, 8, 1, 1, 0, O_NONE);

    // Reset state: outputs low while rst is held, counters cleared
    rst = 1'b1;
    applyStimulus(luV, 1'b1, 1'b0);
    tick();
    tick();
    checkOutput("reset_outputs", 32'(outBits()), 32'(O_NONE));
    checkCounters("reset");
    rst = 1'b0;

    // RUN-state decode table
    for (int i = 0; i < 10; i++) begin
      step($sformatf("vec%0d_out", i), vecs[i], 1'b0, 1'b0, vecs[i].expOut,
           vecs[i].expOut[4], vecs[i].expOut[1]);
      checkCounters($sformatf("vec%0d", i));
    end

    // Halt pulse, four drain cycles, halted, then resume
    step("haltA_req", idleV, 1'b1, 1'b0, O_NONE, 0, 0);
    for (int i = 0; i < 4; i++) begin
      step($sformatf("haltA_drain%0d", i), idleV, 1'b0, 1'b0, O_DRAIN, 0, 0);
    end
    step("haltA_halted0", idleV, 1'b1, 1'b0, O_HALTED, 0, 0);
    step("haltA_halted1", idleV, 1'b0, 1'b0, O_HALTED, 0, 0);
    step("haltA_resume", idleV, 1'b0, 1'b1, O_HALTED, 0, 0);
    applyStimulus(idleV, 1'b0, 1'b0);
    #1;
    checkOutput("haltA_run_after", 32'(outBits()), 32'(O_NONE));
    checkCounters("haltA");

    // Halt in same cycle as a branch; branch and load-use during drain
    step("haltB_req_branch", brV, 1'b1, 1'b0, O_BRANCH, 0, 1);
    step("haltB_drain0", idleV, 1'b0, 1'b0, O_DRAIN, 0, 0);
    step("haltB_drain1_br", brV, 1'b0, 1'b0, O_BRANCH, 0, 1);
    step("haltB_drain2_lu", luV, 1'b0, 1'b0, O_DRLU, 0, 0);
    step("haltB_drain3", idleV, 1'b0, 1'b0, O_DRAIN, 0, 0);
    step("haltB_halted", idleV, 1'b0, 1'b1, O_HALTED, 0, 0);
    step("haltB_run_lu", luV, 1'b0, 1'b0, O_STALL, 1, 0);
    checkCounters("haltB");

    // Reset two cycles into a drain aborts it with no residual hold
    step("rstC_req", idleV, 1'b1, 1'b0, O_NONE, 0, 0);
    step("rstC_drain0", idleV, 1'b0, 1'b0, O_DRAIN, 0, 0);
    step("rstC_drain1", idleV, 1'b0, 1'b0, O_DRAIN, 0, 0);
    rst = 1'b1;
    step("rstC_during", idleV, 1'b0, 1'b0, O_NONE, 0, 0);
    stallExp = 0;
    flushExp = 0;
    checkCounters("rstC");
    rst = 1'b0;
    step("rstC_after_idle", idleV, 1'b0, 1'b0, O_NONE, 0, 0);
    step("rstC_after_lu", luV, 1'b0, 1'b0, O_STALL, 1, 0);
    checkCounters("rstC_lu");

    // Saturation: 2^16+3 consecutive load-use cycles
    applyStimulus(luV, 1'b0, 1'b0);
    for (int i = 0; i < 65539; i++) begin
      tick();
      stallExp = bump(stallExp);
    end
    checkOutput("sat_out", 32'(outBits()), 32'(O_STALL));
    checkOutput("sat_stall_ffff", 32'(hzIf.stall_cnt), 32'h0000_FFFF);
    checkCounters("sat");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter DRAIN_CYCLES, default 4: cycles to empty EX/MEM/WB after fetch stops.
REQ-002 Parameter CNT_W, default 16: width of the performance counters.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 Rs_ID  input  5  rs field of the instruction in ID.
REQ-006 Rt_ID  input  5  rt field of the instruction in ID.
REQ-007 UseRs_ID / UseRt_ID  input  1 each  the ID instruction reads rs / rt.
REQ-008 Rw_Ex  input  5  destination register of the instruction in EX.
REQ-009 RegWr_Ex, MemToReg_Ex  input  1 each  EX instruction writes a register / is a load.
REQ-010 BranchTaken_Ex  input  1  EX resolved a taken branch or jump this cycle.
REQ-011 halt_req / resume  input  1 each  level request to halt / pulse to restart.
REQ-012 pc_hold  output  1  PC keeps its value.
REQ-013 ifid_hold / ifid_flush  output  1 each  IF/ID keeps its value / loads a NOP.
REQ-014 idex_bubble  output  1  ID/EX loads a NOP (all control signals 0).
REQ-015 PC_Src  output  1  PC selects the EX branch/jump target.
REQ-016 halted  output  1  pipeline empty and frozen.
REQ-017 stall_cnt, flush_cnt  output  CNT_W each  load-use stall cycles and flush events.

Function
REQ-018 FSM states: RUN, DRAIN, HALTED.
REQ-019 Load-use hazard (LU): MemToReg_Ex & RegWr_Ex & Rw_Ex!=0 & ((UseRs_ID & Rs_ID==Rw_Ex) | (UseRt_ID & Rt_ID==Rw_Ex)).
REQ-020 Control outputs are combinational from the current state and inputs, with zero latency.
REQ-021 RUN, BranchTaken_Ex=1: PC_Src=1, ifid_flush=1, idex_bubble=1, pc_hold=0, flush_cnt+1.
REQ-022 RUN, LU=1, no branch: pc_hold=1, ifid_hold=1, idex_bubble=1, stall_cnt+1.
   - One cycle only; the next cycle the load is in MEM and LU is false.
REQ-023 Priority: a taken branch suppresses LU, because the ID instruction is on the wrong path.
REQ-024 RUN, halt_req=1: next state DRAIN, drain counter loaded with DRAIN_CYCLES-1.
   - The current cycle's branch/LU handling still applies.
REQ-025 DRAIN: pc_hold=1 and ifid_flush=1 every cycle; the counter decrements each cycle.
   - At 0 the FSM goes to HALTED.
   - LU in DRAIN: idex_bubble=1 and ifid_hold=0; the flush still proceeds and the counter is unaffected.
REQ-026 DRAIN, BranchTaken_Ex=1: PC_Src=1, pc_hold=0 so the PC loads the target, ifid_flush=1, idex_bubble=1, flush_cnt+1; the counter continues.
REQ-027 HALTED: halted=1, pc_hold=1, ifid_flush=1, idex_bubble=1.
   - resume=1 returns the FSM to RUN the next cycle; halt_req is ignored in this state.
REQ-028 resume outside HALTED is ignored; halt_req deasserted during DRAIN does not abort DRAIN.
REQ-029 Counters saturate at all-ones and never wrap.

Reset
REQ-030 While rst=1 the FSM is forced to RUN, the drain counter and both perf counters go to 0, and every control output is 0.
REQ-031 rst asserted mid-DRAIN or mid-stall aborts the operation immediately; there is no residual hold on the first cycle after reset.

Structure
REQ-032 A shared package hazard_pkg holds the state enum (RUN=0, DRAIN=1, HALTED=2) and the DRAIN_CYCLES default.
REQ-033 A single sub-module, sat_counter, is instantiated twice for the perf counters.
REQ-034 The FSM, LU compare and output decode stay in hazard_ctrl.

Verification
REQ-035 Load-use: Rw_Ex=8, MemToReg_Ex=1, RegWr_Ex=1, Rs_ID=8, UseRs_ID=1 -> pc_hold=ifid_hold=idex_bubble=1 for 1 cycle, stall_cnt=1.
REQ-036 Load to $0: same as REQ-035 but Rw_Ex=0 and Rs_ID=0 -> no stall, stall_cnt stays 0.
REQ-037 Branch plus LU in the same cycle -> PC_Src=1, ifid_flush=1, idex_bubble=1, pc_hold=0, stall_cnt unchanged, flush_cnt=1.
REQ-038 Halt/resume: halt_req pulsed in RUN -> 4 cycles of DRAIN, then halted=1; resume pulse -> RUN the next cycle and halted=0.
REQ-039 Reset in DRAIN after 2 cycles -> next cycle state RUN, all outputs 0, counters 0.
REQ-040 Saturation: 2^16+3 LU cycles -> stall_cnt=16'hFFFF.
